logic_gate_tester: RTL and testbench



---
 rtl/logic_gate_tester.sv | 178 +++++++++++++++++
 tb/tb_logic_gate_tester.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gate_tester.sv
// BIST initiator for the two-input logic gate unit: sweeps {a,b}, compares the eight gate outputs, reports results.
// Optional build macro LGT_STOP_ON_FAIL_EN: end the run at the first mismatching compare.
module logic_gate_tester #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned SWEEPS        = 1,
  parameter int unsigned ERR_W         = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       resp,
  output logic             test_a,
  output logic             test_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       fail_mask,
  output logic [1:0]       first_fail_vec,
  output logic             first_fail_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam int unsigned ST_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned SW_W  = (SWEEPS > 1) ? $clog2(SWEEPS) : 1;
  localparam int unsigned SUM_W = ERR_W + 4;

  localparam logic [ST_W-1:0]  SETTLE_LAST = ST_W'(SETTLE_CYCLES - 1);
  localparam logic [SW_W-1:0]  SWEEP_LAST  = SW_W'(SWEEPS - 1);
  localparam logic [SUM_W-1:0] ERR_MAX     = {4'b0000, {ERR_W{1'b1}}};

`ifdef LGT_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  // Bit map: 7 xnor, 6 xor, 5 nor, 4 nand, 3 not_b, 2 not_a, 1 or, 0 and.
  function automatic logic [7:0] expected_resp(input logic [1:0] ab);
    logic [7:0] r;
    case (ab)
      2'b00:   r = 8'hBC;
      2'b01:   r = 8'h56;
      2'b10:   r = 8'h5A;
      default: r = 8'h83;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [ST_W-1:0]  settle_q, settle_d;
  logic [SW_W-1:0]  sweep_q, sweep_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [7:0]       mask_q, mask_d;
  logic [1:0]       ffv_q, ffv_d;
  logic             ffvalid_q, ffvalid_d;
  logic             pass_q, pass_d;

  logic [7:0]       mismatch;
  logic [SUM_W-1:0] err_sum;
  logic [ERR_W-1:0] err_sat;
  logic             compare_now;
  logic             last_compare;

  assign mismatch     = resp ^ expected_resp(idx_q);
  assign err_sum      = {4'b0000, err_q} + SUM_W'(popcount8(mismatch));
  assign err_sat      = (err_sum > ERR_MAX) ? ERR_MAX[ERR_W-1:0] : err_sum[ERR_W-1:0];
  assign compare_now  = (state_q == S_RUN) && (settle_q == SETTLE_LAST);
  assign last_compare = (idx_q == 2'd3) && (sweep_q == SWEEP_LAST);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    settle_d  = settle_q;
    sweep_d   = sweep_q;
    err_d     = err_q;
    mask_d    = mask_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    pass_d    = pass_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          idx_d     = '0;
          settle_d  = '0;
          sweep_d   = '0;
          err_d     = '0;
          mask_d    = '0;
          ffv_d     = '0;
          ffvalid_d = 1'b0;
          pass_d    = 1'b0;
        end
      end

      S_RUN: begin
        if (!compare_now) begin
          settle_d = settle_q + 1'b1;
        end else begin
          settle_d = '0;
          err_d    = err_sat;
          mask_d   = mask_q | mismatch;
          if ((mismatch != 8'h00) && !ffvalid_q) begin
            ffv_d     = idx_q;
            ffvalid_d = 1'b1;
          end
          // Index wraps 11 -> 00; the sweep counter advances on the wrap.
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            sweep_d = sweep_q + 1'b1;
          end
          if (last_compare || (STOP_ON_FAIL && (mismatch != 8'h00))) begin
            state_d = S_DONE;
            pass_d  = (err_sat == '0);
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      settle_q  <= '0;
      sweep_q   <= '0;
      err_q     <= '0;
      mask_q    <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      settle_q  <= settle_d;
      sweep_q   <= sweep_d;
      err_q     <= err_d;
      mask_q    <= mask_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
      pass_q    <= pass_d;
    end
  end

  // Stimulus is only driven while running; IDLE and DONE park the inputs at 00.
  assign busy             = (state_q == S_RUN);
  assign done             = (state_q == S_DONE);
  assign test_a           = busy & idx_q[1];
  assign test_b           = busy & idx_q[0];
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign fail_mask        = mask_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_logic_gate_tester.sv
// Self-checking bench for logic_gate_tester: table vectors, hand-written reset/restart sequences and random fault tables.
module tb_logic_gate_tester;

  localparam int S0 = 2;
  localparam int W0 = 1;
  localparam int S1 = 3;
  localparam int W1 = 2;
  localparam int EW = 6;
  localparam int ERR_SAT = (1 << EW) - 1;

`ifdef LGT_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [3:0][7:0] err_tab;

  logic [7:0]    resp [2];
  logic          test_a [2];
  logic          test_b [2];
  logic          busy [2];
  logic          done [2];
  logic          pass [2];
  logic [EW-1:0] err_count [2];
  logic [7:0]    fail_mask [2];
  logic [1:0]    ffv [2];
  logic          ffvalid [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Behavioural gate unit; err_tab flips selected output bits per input vector.
  function automatic logic [7:0] golden(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~b, ~a, a | b, a & b};
  endfunction

  assign resp[0] = golden(test_a[0], test_b[0]) ^ err_tab[{test_a[0], test_b[0]}];
  assign resp[1] = golden(test_a[1], test_b[1]) ^ err_tab[{test_a[1], test_b[1]}];

  logic_gate_tester #(.SETTLE_CYCLES(S0), .SWEEPS(W0), .ERR_W(EW)) u0 (
    .clk(clk), .rst(rst), .start(start), .resp(resp[0]),
    .test_a(test_a[0]), .test_b(test_b[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .err_count(err_count[0]), .fail_mask(fail_mask[0]),
    .first_fail_vec(ffv[0]), .first_fail_valid(ffvalid[0])
  );

  logic_gate_tester #(.SETTLE_CYCLES(S1), .SWEEPS(W1), .ERR_W(EW)) u1 (
    .clk(clk), .rst(rst), .start(start), .resp(resp[1]),
    .test_a(test_a[1]), .test_b(test_b[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .err_count(err_count[1]), .fail_mask(fail_mask[1]),
    .first_fail_vec(ffv[1]), .first_fail_valid(ffvalid[1])
  );

  typedef struct {
    int         done_c;
    int         err;
    logic [7:0] mask;
    logic [1:0] first;
    logic       valid;
    logic       pass_v;
  } exp_t;

  typedef struct {
    string           name;
    logic [3:0][7:0] tab;
    int              done_c;
    int              err;
    logic [7:0]      mask;
    logic [1:0]      first;
    logic            valid;
    logic            pass_v;
    int              done_stop;
    int              err_stop;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: walk the compare sequence of a run and tally results directly from the rules.
  function automatic exp_t model(input logic [3:0][7:0] tab, input int s, input int w);
    exp_t e;
    int   acc;
    acc      = 0;
    e.mask   = '0;
    e.first  = '0;
    e.valid  = 1'b0;
    e.done_c = 4 * s * w + 1;
    for (int n = 0; n < 4 * w; n++) begin
      int v;
      v = n % 4;
      if (tab[v] != 8'h00) begin
        acc += $countones(tab[v]);
        e.mask |= tab[v];
        if (!e.valid) begin
          e.valid = 1'b1;
          e.first = v[1:0];
        end
        if (STOP) begin
          e.done_c = s * (n + 1) + 1;
          break;
        end
      end
    end
    e.err    = (acc > ERR_SAT) ? ERR_SAT : acc;
    e.pass_v = (acc == 0);
    return e;
  endfunction

  task automatic check_results(input string tag, input int k, input exp_t e);
    check($sformatf("%s u%0d err_count", tag, k), 32'(err_count[k]), 32'(e.err));
    check($sformatf("%s u%0d fail_mask", tag, k), 32'(fail_mask[k]), 32'(e.mask));
    check($sformatf("%s u%0d first_vec", tag, k), 32'(ffv[k]), 32'(e.first));
    check($sformatf("%s u%0d first_valid", tag, k), 32'(ffvalid[k]), 32'(e.valid));
    check($sformatf("%s u%0d pass", tag, k), 32'(pass[k]), 32'(e.pass_v));
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s u%0d outputs", tag, k),
            32'({test_a[k], test_b[k], busy[k], done[k], pass[k], ffvalid[k], ffv[k], fail_mask[k], err_count[k]}),
            32'h0);
    end
  endtask

  // Called at a negedge: start is raised at once, so the next rising edge is E0.
  task automatic run(input string name, input logic [3:0][7:0] tab, input int restart_c, input exp_t e0);
    exp_t e [2];
    int   limit;
    int   s;
    logic [3:0] et;
    e[0]    = e0;
    e[1]    = model(tab, S1, W1);
    err_tab = tab;
    limit   = ((e[0].done_c > e[1].done_c) ? e[0].done_c : e[1].done_c) + 2;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        s = (k == 0) ? S0 : S1;
        if (c < e[k].done_c)       et = {2'b10, 2'(((c - 1) / s) % 4)};
        else if (c == e[k].done_c) et = 4'b0100;
        else                       et = 4'b0000;
        check($sformatf("%s u%0d cyc%0d busy/done/ab", name, k, c),
              32'({busy[k], done[k], test_a[k], test_b[k]}), 32'(et));
        if (c == e[k].done_c) check_results($sformatf("%s done", name), k, e[k]);
      end
      start = (c == restart_c);
    end
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s u%0d hold err_count", name, k), 32'(err_count[k]), 32'(e[k].err));
      check($sformatf("%s u%0d hold pass", name, k), 32'(pass[k]), 32'(e[k].pass_v));
    end
  endtask

  initial begin
    vec_t vt [4];
    exp_t e0;
    exp_t e1;
    logic [3:0][7:0] tab;
    int restart;
    int lim;

    vt[0] = '{"golden",   32'h0000_0000, 9, 0,  8'h00, 2'd0, 1'b0, 1'b1, 9, 0};
    vt[1] = '{"xor_sa0",  32'h0040_4000, 9, 2,  8'h40, 2'd1, 1'b1, 1'b0, 5, 1};
    vt[2] = '{"inverted", 32'hFFFF_FFFF, 9, 32, 8'hFF, 2'd0, 1'b1, 1'b0, 3, 8};
    vt[3] = '{"and_sa1",  32'h0001_0101, 9, 3,  8'h01, 2'd0, 1'b1, 1'b0, 3, 1};

    rst     = 1'b1;
    start   = 1'b0;
    err_tab = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      e0.done_c = STOP ? vt[i].done_stop : vt[i].done_c;
      e0.err    = STOP ? vt[i].err_stop : vt[i].err;
      e0.mask   = vt[i].mask;
      e0.first  = vt[i].first;
      e0.valid  = vt[i].valid;
      e0.pass_v = vt[i].pass_v;
      // Golden run gets a start re-pulse mid-run; the inverted run gets one in u0's DONE cycle.
      restart = (i == 0) ? 3 : (i == 2) ? e0.done_c : 0;
      run(vt[i].name, vt[i].tab, restart, e0);
    end

    // rst in cycle 5 of a run, then start in the first cycle after release.
    err_tab = 32'hFFFF_FFFF;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 5; c++) @(negedge clk);
    check("midrun u0 err_count", 32'(err_count[0]), STOP ? 32'd8 : 32'd16);
    check("midrun u1 err_count", 32'(err_count[1]), 32'd8);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("after midrun rst");
    rst = 1'b0;
    run("post_rst_golden", 32'h0000_0000, 0, model(32'h0000_0000, S0, W0));

    for (int it = 0; it < 20; it++) begin
      for (int j = 0; j < 4; j++) begin
        case ($urandom_range(0, 2))
          0:       tab[j] = 8'h00;
          1:       tab[j] = 8'h01 << $urandom_range(0, 7);
          default: tab[j] = 8'($urandom);
        endcase
      end
      e0      = model(tab, S0, W0);
      e1      = model(tab, S1, W1);
      lim     = (e0.done_c < e1.done_c) ? e0.done_c : e1.done_c;
      restart = ($urandom_range(0, 1) == 1) ? $urandom_range(1, lim) : 0;
      run($sformatf("rand%0d", it), tab, restart, e0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
